// File: rtl/gmsk_demodulate.sv
// gmsk_demodulate: non-coherent one-bit differential GMSK demodulator.
// Discriminator Im(z[n]*conj(z[n-SPS])) = Q[n]*I[n-SPS] - I[n]*Q[n-SPS],
// sliced once per symbol at SAMPLE_PHASE. Three-stage pipeline, fixed latency.
// Optional macro GMSK_DEMOD_TIMING_TRACK_EN adds an early-late timing tracker
// and the timing_adj output port.
module gmsk_demodulate #(
  parameter int IQ_WIDTH           = 8,
  parameter int SAMPLES_PER_SYMBOL = 31,
  parameter int SAMPLE_PHASE       = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [IQ_WIDTH-1:0]   inphase_in,
  input  logic [IQ_WIDTH-1:0]   quadrature_in,
  output logic                  symbol_out,
  output logic                  symbol_strobe,
  output logic [2*IQ_WIDTH:0]   disc_out
`ifdef GMSK_DEMOD_TIMING_TRACK_EN
  ,
  output logic [1:0]            timing_adj
`endif
);

  localparam int SPS = SAMPLES_PER_SYMBOL;
  localparam int CW  = $clog2(SPS + 1);
  localparam int PW  = 2 * IQ_WIDTH;
  localparam logic [CW-1:0] LAST_C  = CW'(SPS - 1);
  localparam logic [CW-1:0] FULL_C  = CW'(SPS);
  localparam logic [CW-1:0] PHASE_C = CW'(SAMPLE_PHASE);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [PW-1:0]              dl_q [SPS];
  logic [CW-1:0]              cnt_q, cnt_d, fill_q, fill_d;
  logic signed [IQ_WIDTH-1:0] cur_i, cur_q, old_i, old_q;
  logic                       wrap, eligible, accept_dec;
  logic signed [PW-1:0]       a_q, b_q;
  logic signed [PW:0]         disc_d, disc_q;
  logic                       v1_q, dec1_q, dec2_q, symbol_q, strobe_q;

  assign cur_i      = $signed(inphase_in);
  assign cur_q      = $signed(quadrature_in);
  assign old_i      = $signed(dl_q[SPS-1][PW-1:IQ_WIDTH]);
  assign old_q      = $signed(dl_q[SPS-1][IQ_WIDTH-1:0]);
  assign wrap       = sample_valid && (cnt_q == LAST_C);
  assign eligible   = (fill_q == FULL_C);
  assign accept_dec = sample_valid && eligible && (cnt_q == PHASE_C);
  // Sign-extend both products by one bit so the difference cannot overflow.
  assign disc_d     = {a_q[PW-1], a_q} - {b_q[PW-1], b_q};

`ifdef GMSK_DEMOD_TIMING_TRACK_EN
  localparam logic [CW-1:0] EARLY_C = CW'((SAMPLE_PHASE + SPS - 1) % SPS);
  localparam logic [CW-1:0] LATE_C  = CW'((SAMPLE_PHASE + 1) % SPS);
  logic [PW:0] mag_d, early_mag_q;
  logic        early1_q, late1_q, early_seen_q, adv_pend_q, ret_pend_q;
  logic [1:0]  adj_q;
  assign mag_d      = disc_d[PW] ? -disc_d : disc_d;
  assign timing_adj = adj_q;
`endif

  // Next symbol count and saturating fill count; tracker may bend the wrap.
  always_comb begin
    cnt_d  = cnt_q;
    fill_d = fill_q;
    if (sample_valid) begin
      if (cnt_q == LAST_C) begin
`ifdef GMSK_DEMOD_TIMING_TRACK_EN
        if (adv_pend_q)      cnt_d = ONE_C;
        else if (ret_pend_q) cnt_d = LAST_C;
        else                 cnt_d = '0;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + ONE_C;
      end
      if (fill_q != FULL_C) fill_d = fill_q + ONE_C;
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      fill_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
    end
  end

  // SPS-deep {I,Q} delay line; contents are masked by the fill counter.
  always_ff @(posedge clock) begin
    if (sample_valid) begin
      dl_q[0] <= {inphase_in, quadrature_in};
      for (int k = 1; k < SPS; k++) dl_q[k] <= dl_q[k-1];
    end
  end

  // Stage 1 datapath: full-precision cross products against the delayed sample.
  always_ff @(posedge clock) begin
    a_q <= PW'(cur_q) * PW'(old_i);
    b_q <= PW'(cur_i) * PW'(old_q);
  end

  // Stage 1 control: valid and decision tags travel with the products.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v1_q   <= 1'b0;
      dec1_q <= 1'b0;
    end else begin
      v1_q   <= sample_valid;
      dec1_q <= accept_dec;
    end
  end

  // Stage 2: discriminator register, refreshed only by valid samples.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      disc_q <= '0;
      dec2_q <= 1'b0;
    end else begin
      if (v1_q) disc_q <= disc_d;
      dec2_q <= dec1_q;
    end
  end

  // Stage 3: sign slice (strictly positive decodes as 1) and strobe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      symbol_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= dec2_q;
      if (dec2_q) symbol_q <= !disc_q[PW] && (disc_q != '0);
    end
  end

`ifdef GMSK_DEMOD_TIMING_TRACK_EN
  // Stage 1 tags for the samples either side of the decision phase.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      early1_q <= 1'b0;
      late1_q  <= 1'b0;
    end else begin
      early1_q <= sample_valid && eligible && (cnt_q == EARLY_C);
      late1_q  <= sample_valid && eligible && (cnt_q == LATE_C);
    end
  end

  // Early-late compare: one pending adjustment, consumed at the next wrap.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      early_mag_q  <= '0;
      early_seen_q <= 1'b0;
      adv_pend_q   <= 1'b0;
      ret_pend_q   <= 1'b0;
      adj_q        <= 2'b00;
    end else begin
      adj_q <= 2'b00;
      if (wrap) begin
        adv_pend_q <= 1'b0;
        ret_pend_q <= 1'b0;
      end
      if (early1_q) begin
        early_mag_q  <= mag_d;
        early_seen_q <= 1'b1;
      end
      if (late1_q && early_seen_q) begin
        early_seen_q <= 1'b0;
        if (early_mag_q > mag_d) begin
          adj_q      <= 2'b01;
          adv_pend_q <= 1'b1;
          ret_pend_q <= 1'b0;
        end else if (early_mag_q < mag_d) begin
          adj_q      <= 2'b10;
          ret_pend_q <= 1'b1;
          adv_pend_q <= 1'b0;
        end
      end
    end
  end
`endif

  assign symbol_out    = symbol_q;
  assign symbol_strobe = strobe_q;
  assign disc_out      = disc_q;

endmodule

// File: doc/gmsk_demodulate.md
Name: gmsk_demodulate

Overview:
Non-coherent one-bit differential GMSK demodulator; the receive-side counterpart of the GMSK I/Q modulator. Ingests signed I/Q samples at SAMPLES_PER_SYMBOL samples per symbol and computes the one-symbol-delayed phase discriminator Im(z[n]·conj(z[n-SPS])). Once per symbol it slices the discriminator sign into a bit. Sits between the baseband sample source (ADC path, or the modulator in loopback) and the burst/framing logic.

Parameters:
IQ_WIDTH, 8, signed two's-complement width of the I and Q inputs; matches the modulator output width.
SAMPLES_PER_SYMBOL, 31, samples per symbol; also the delay-line depth (≥4).
SAMPLE_PHASE, 15, symbol-counter value at which the decision is taken (0..SPS-1).

Ports:
clock  in  1  single system clock; all logic on posedge.
reset_n  in  1  synchronous, active-low reset.
sample_valid  in  1  qualifies inphase_in/quadrature_in for one cycle; may be sparse or continuous.
inphase_in  in  IQ_WIDTH  signed I sample.
quadrature_in  in  IQ_WIDTH  signed Q sample.
symbol_out  out  1  decided bit; holds until the next decision.
symbol_strobe  out  1  one-cycle pulse when symbol_out is updated.
disc_out  out  2*IQ_WIDTH+1  signed discriminator for the most recent valid sample (debug/monitor).

Behaviour:
- Reset (reset_n=0 at a posedge): symbol_out=0, symbol_strobe=0, disc_out=0. Symbol counter, fill counter and all pipeline valid bits are cleared. Delay-line contents need not be cleared because warm-up masks them. Mid-stream reset aborts any in-flight decision, and no strobe follows.
- Delay line: a SPS-deep shift of {I,Q} that advances only on sample_valid. The delayed output is the sample accepted SPS valids earlier.
- Stage 1 (clock after the valid cycle): register a = Q[n]·I[n-SPS] and b = I[n]·Q[n-SPS]. These are full-precision signed 2*IQ_WIDTH products.
- Stage 2: disc = a - b, sign-extended to 2*IQ_WIDTH+1, so it cannot overflow. disc_out updates here.
- Stage 3: decision and strobe.
- Pipeline registers advance every clock, each carrying its own valid bit. Total latency is fixed: symbol_strobe fires exactly 3 cycles after the sample_valid cycle of the decision sample.
- Symbol counter: 0..SPS-1, increments on each sample_valid and wraps to 0 after SPS-1. Each sample is tagged with the count it was accepted at.
- Fill counter: saturates at SPS. A sample is decision-eligible only if ≥SPS samples were accepted before it, i.e. the delay line is full.
- Decision: an eligible sample tagged with count==SAMPLE_PHASE produces symbol_out = (disc>0) and symbol_strobe=1 for that one cycle. disc≤0 gives 0.
- Polarity: positive phase advance (quadrant accumulator +1 at the modulator) decodes as 1.
- Gaps in sample_valid stall the counters and delay line but not the pipeline. In-flight samples still complete.

Optional Feature:
GMSK_DEMOD_TIMING_TRACK_EN.
- Defined: early-late timing tracker. Latch |disc| for eligible samples tagged SAMPLE_PHASE-1 (early) and SAMPLE_PHASE+1 (late), mod SPS.
  - When the late sample's disc is available: early>late → the next wrap skips count 0 (advance 1 sample); late>early → the counter holds at SPS-1 for one extra valid (retard 1 sample); equal → no change.
  - At most one adjustment per symbol.
  - Adds output timing_adj[1:0] (01 advance, 10 retard, 00 none, one-cycle pulse). Reset clears it to 00.
- Undefined: counter is free-running exactly as above, and the port is absent.

Test Plan:
- Reset: hold reset_n=0 for 5 clocks with sample_valid=1 → symbol_out=0, symbol_strobe=0, disc_out=0 throughout. Release → no strobe until sample index 31+15.
- Static phase: I=100, Q=0 continuous → disc_out=0 after warm-up; strobe every 31 valids, symbol_out=0.
- Positive step: 31 samples (100,0), then (0,100) → decision sample disc=+10000, symbol_out=1, strobe 3 cycles after that sample's valid.
- Loopback: modulator → demodulator, bit pattern 1,1,0,1,0,0,1,0 repeated, SAMPLE_PHASE tuned to loop delay → recovered bits match after fixed lag; check strobe spacing =31 valids.
- Sparse valid: same stream with sample_valid every 3rd clock → identical bit sequence and disc_out values; strobe latency still 3 clocks.
- Mid-burst reset: reset_n=0 for 1 clock between a decision sample's valid and its strobe → no strobe; full warm-up repeats.
- (TRACK_EN) Input shifted 2 samples early → two advance pulses on timing_adj, then 00, with decisions correct.
